// File: rtl/nf_seq_ctrl_if.sv
// nf_seq_ctrl_if: imem handshake, decoder flags and datapath strobes of the nanoFOX sequencer
interface nf_seq_ctrl_if;
  logic imem_req;
  logic imem_ack;
  logic instr_le;
  logic we_dec;
  logic branch_dec;
  logic eq_neq;
  logic zero;
  logic rf_we;
  logic pc_we;
  logic pc_src;
  modport master (
    output imem_req, instr_le, rf_we, pc_we, pc_src,
    input  imem_ack, we_dec, branch_dec, eq_neq, zero
  );
  modport slave (
    input  imem_req, instr_le, rf_we, pc_we, pc_src,
    output imem_ack, we_dec, branch_dec, eq_neq, zero
  );
endinterface

// File: rtl/nf_seq_ctrl.sv
// nf_seq_ctrl: multi-cycle FETCH/DECODE/EXEC/WB sequencer with fetch timeout, debug halt and instret
module nf_seq_ctrl #(
  parameter int TIMEOUT = 16,
  parameter int CNT_W   = 32
) (
  input  logic               clk,
  input  logic               reset,
  nf_seq_ctrl_if.master      bus,
  input  logic               halt_req,
  output logic               halted,
  output logic               fault,
  output logic [2:0]         state,
  output logic [CNT_W-1:0]   instret
);
  localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  typedef enum logic [2:0] {
    FETCH  = 3'd0,
    DECODE = 3'd1,
    EXEC   = 3'd2,
    WB     = 3'd3,
    HALT   = 3'd4,
    FAULT  = 3'd5
  } state_t;
  state_t st, nxt;
  logic [TW-1:0] tmo, tmo_nxt;
  logic [CNT_W-1:0] ret;
  logic req, le, rw, pw, ps, hl, fl;
  // state, fetch timeout counter and retired count; retire happens on leaving WB
  always_ff @(posedge clk) begin
    if (reset) begin
      st  <= FETCH;
      tmo <= '0;
      ret <= '0;
    end else begin
      st  <= nxt;
      tmo <= tmo_nxt;
      if (st == WB) ret <= ret + 1'b1;
    end
  end
  // next state and raw strobes; reset masking is applied on the outputs below
  always_comb begin
    nxt     = st;
    tmo_nxt = tmo;
    req     = 1'b0;
    le      = 1'b0;
    rw      = 1'b0;
    pw      = 1'b0;
    ps      = 1'b0;
    hl      = 1'b0;
    fl      = 1'b0;
    case (st)
      FETCH: begin
        req = 1'b1;
        le  = bus.imem_ack;
        if (bus.imem_ack) begin
          nxt     = DECODE;
          tmo_nxt = '0;
        end else begin
          tmo_nxt = tmo + 1'b1;
          if (TIMEOUT != 0 && tmo == TW'(TIMEOUT - 1)) nxt = FAULT;
        end
      end
      DECODE: nxt = EXEC;
      EXEC:   nxt = WB;
      WB: begin
        pw  = 1'b1;
        ps  = bus.branch_dec & (bus.eq_neq ? bus.zero : ~bus.zero);
        rw  = bus.we_dec & ~bus.branch_dec;
        nxt = halt_req ? HALT : FETCH;
      end
      HALT: begin
        hl  = 1'b1;
        nxt = halt_req ? HALT : FETCH;
      end
      FAULT:   fl  = 1'b1;
      default: nxt = FAULT;
    endcase
  end
  assign bus.imem_req = req & ~reset;
  assign bus.instr_le = le & ~reset;
  assign bus.rf_we    = rw & ~reset;
  assign bus.pc_we    = pw & ~reset;
  assign bus.pc_src   = ps & ~reset;
  assign halted       = hl & ~reset;
  assign fault        = fl & ~reset;
  assign state        = reset ? 3'd0 : st;
  assign instret      = reset ? '0 : ret;
endmodule

// File: tb/tb_nf_seq_ctrl.sv
// tb_nf_seq_ctrl: transaction-level model of the sequencer checked cycle by cycle with immediate assertions
module tb_nf_seq_ctrl;
  logic clk = 1'b0;
  logic reset;
  logic halt_req;
  logic halted, fault;
  logic [2:0] state;
  logic [3:0] instret;
  int n_cmp = 0;
  int n_err = 0;
  int ret = 0;
  nf_seq_ctrl_if bus();
  nf_seq_ctrl #(.TIMEOUT(16), .CNT_W(4)) dut (
    .clk(clk), .reset(reset), .bus(bus), .halt_req(halt_req),
    .halted(halted), .fault(fault), .state(state), .instret(instret)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  task automatic cyc(input string t, input int s, input bit rq, input bit le, input bit rw,
                     input bit pw, input bit h, input bit f, input bit cps, input bit ps);
    @(negedge clk);
    chk({t, ".state"}, 32'(state), 32'(s));
    chk({t, ".imem_req"}, 32'(bus.imem_req), 32'(rq));
    chk({t, ".instr_le"}, 32'(bus.instr_le), 32'(le));
    chk({t, ".rf_we"}, 32'(bus.rf_we), 32'(rw));
    chk({t, ".pc_we"}, 32'(bus.pc_we), 32'(pw));
    chk({t, ".halted"}, 32'(halted), 32'(h));
    chk({t, ".fault"}, 32'(fault), 32'(f));
    chk({t, ".instret"}, 32'(instret), 32'(ret));
    if (cps) chk({t, ".pc_src"}, 32'(bus.pc_src), 32'(ps));
    @(posedge clk);
    #1;
  endtask
  task automatic rnd_dec();
    bus.we_dec     = 1'($urandom);
    bus.branch_dec = 1'($urandom);
    bus.eq_neq     = 1'($urandom);
    bus.zero       = 1'($urandom);
  endtask
  task automatic instr(input int lat, input bit we, input bit br, input bit eq, input bit z, input int hold);
    halt_req = (hold > 0);
    for (int i = 0; i <= lat; i++) begin
      bus.imem_ack = (i == lat);
      rnd_dec();
      cyc("fetch", 0, 1, i == lat, 0, 0, 0, 0, 0, 0);
    end
    bus.imem_ack = 1'($urandom);
    rnd_dec();
    cyc("decode", 1, 0, 0, 0, 0, 0, 0, 0, 0);
    bus.imem_ack = 1'($urandom);
    rnd_dec();
    cyc("exec", 2, 0, 0, 0, 0, 0, 0, 0, 0);
    bus.imem_ack   = 1'($urandom);
    bus.we_dec     = we;
    bus.branch_dec = br;
    bus.eq_neq     = eq;
    bus.zero       = z;
    cyc("wb", 3, 0, 0, we & ~br, 1, 0, 0, 1, br & (eq == z));
    ret = (ret + 1) % 16;
    if (hold > 0) begin
      for (int i = 0; i < hold; i++) begin
        bus.imem_ack = 1'($urandom);
        cyc("halt", 4, 0, 0, 0, 0, 1, 0, 0, 0);
      end
      halt_req = 1'b0;
      cyc("halt_exit", 4, 0, 0, 0, 0, 1, 0, 0, 0);
    end
  endtask
  initial begin
    reset = 1'b1;
    halt_req = 1'b0;
    bus.imem_ack = 1'b1;
    rnd_dec();
    @(posedge clk);
    #1;
    cyc("reset", 0, 0, 0, 0, 0, 0, 0, 1, 0);
    reset = 1'b0;
    for (int k = 0; k < 5; k++) instr(0, 1, 0, 0, 0, 0);
    chk("addi_instret", 32'(instret), 32'd5);
    instr(0, 1, 1, 1, 1, 0);
    instr(0, 1, 1, 1, 0, 0);
    instr(0, 1, 1, 0, 1, 0);
    instr(0, 1, 1, 0, 0, 0);
    instr(5, 1, 0, 0, 0, 0);
    halt_req = 1'b0;
    for (int k = 0; k < 20; k++)
      instr($urandom_range(0, 5), 1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom),
            ($urandom_range(0, 3) == 0) ? $urandom_range(1, 4) : 0);
    instr(0, 1, 0, 0, 0, 10);
    bus.imem_ack = 1'b0;
    for (int i = 0; i < 16; i++) cyc("tmo_fetch", 0, 1, 0, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 4; i++) begin
      bus.imem_ack = 1'b1;
      halt_req = 1'($urandom);
      cyc("fault", 5, 0, 0, 0, 0, 0, 1, 0, 0);
    end
    halt_req = 1'b0;
    reset = 1'b1;
    ret = 0;
    cyc("fault_reset", 0, 0, 0, 0, 0, 0, 0, 0, 0);
    reset = 1'b0;
    instr(2, 1, 0, 0, 0, 0);
    bus.imem_ack = 1'b1;
    cyc("er_fetch", 0, 1, 1, 0, 0, 0, 0, 0, 0);
    cyc("er_decode", 1, 0, 0, 0, 0, 0, 0, 0, 0);
    reset = 1'b1;
    ret = 0;
    cyc("er_exec_reset", 0, 0, 0, 0, 0, 0, 0, 0, 0);
    reset = 1'b0;
    for (int k = 0; k < 15; k++) instr($urandom_range(0, 2), 1, 0, 0, 0, 0);
    chk("pre_wrap", 32'(instret), 32'd15);
    instr(0, 1, 0, 0, 0, 0);
    chk("wrap", 32'(instret), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/nf_seq_ctrl.md
Name: nf_seq_ctrl

Overview:
- Multi-cycle sequencer for the nanoFOX core datapath.
- Steps each instruction through FETCH, DECODE, EXEC and WB.
- Generates the imem request handshake, instruction-register load, PC update and register-file write strobe from the decoder's we/branch/eq_neq outputs.
- Adds a fetch timeout fault, debug halt at instruction boundaries and a retired-instruction counter.

Parameters:
- TIMEOUT, 16: max cycles in FETCH without imem_ack before FAULT. 0 disables the timeout.
- CNT_W, 32: width of instret.

Ports:
- clk  in  1  core clock
- reset  in  1  synchronous reset, active-high
- imem_req  out  1  instruction fetch request
- imem_ack  in  1  fetch data valid / request accepted
- instr_le  out  1  load enable for the instruction register
- we_dec  in  1  register write request from the decoder
- branch_dec  in  1  branch instruction flag from the decoder
- eq_neq  in  1  branch condition: 1 = BEQ, 0 = BNE
- zero  in  1  ALU result == 0
- rf_we  out  1  register file write enable (one-cycle pulse)
- pc_we  out  1  PC register write enable (one-cycle pulse)
- pc_src  out  1  PC mux select: 0 = PC+4, 1 = branch target
- halt_req  in  1  debug halt request (level)
- halted  out  1  core is in HALT
- fault  out  1  core is in FAULT
- state  out  3  encoded state: FETCH=0, DECODE=1, EXEC=2, WB=3, HALT=4, FAULT=5
- instret  out  CNT_W  retired-instruction count

Behaviour:
- Reset: clk-synchronous; takes priority over all other inputs. While reset is high:
  - state = FETCH, instret = 0, timeout counter = 0.
  - Every output is forced to 0, including imem_req.
  - Reset asserted in any state, including HALT and FAULT, returns the block to FETCH on the next edge.
- FETCH:
  - imem_req = 1.
  - instr_le = imem_req & imem_ack, combinational. An ack in the first FETCH cycle is legal, giving 1-cycle fetch latency.
  - On ack: go to DECODE and clear the timeout counter.
  - Without ack: the counter increments. When TIMEOUT != 0 and the counter = TIMEOUT-1 with no ack, go to FAULT.
  - Ack has priority over timeout in the same cycle.
  - imem_ack outside FETCH is ignored.
- DECODE: one cycle; all strobes 0; go to EXEC.
- EXEC: one cycle; all strobes 0; go to WB.
- WB: one cycle.
  - pc_we = 1.
  - taken = branch_dec & (eq_neq ? zero : ~zero); pc_src = taken.
  - rf_we = we_dec & ~branch_dec. The decoder asserts we for branches, so the controller must mask it.
  - instret increments by 1, wrapping modulo 2^CNT_W.
  - Next state: HALT if halt_req = 1, else FETCH.
- HALT:
  - halted = 1; all strobes 0; instret is held.
  - Go to FETCH on the first cycle halt_req = 0.
  - halt_req asserted in FETCH, DECODE or EXEC has no effect until WB. An in-flight instruction always completes.
- FAULT:
  - fault = 1; all strobes 0.
  - Leave only via reset. halt_req is ignored.
- Cycles per instruction = 3 + fetch latency, giving 4 minimum.
- Decoder inputs and zero are sampled only in WB; their values in other states are don't-care.
- Strobes (imem_req, instr_le, rf_we, pc_we) are derived from the state only (plus imem_ack for instr_le); no output depends on halt_req.
- Unused state encodings (6, 7) go to FAULT.

Test Plan:
- Reset released, imem_ack tied high, we_dec = 1, branch_dec = 0 (ADDI):
  - Required waveform: imem_req=1 in cycle 0, instr_le in cycle 0, rf_we and pc_we in cycle 3 with pc_src = 0.
  - Repeats every 4 cycles; instret = 5 after 20 cycles.
- BEQ: branch_dec = 1, we_dec = 1, eq_neq = 1.
  - zero = 1 → in WB: pc_src = 1, rf_we = 0, pc_we = 1.
  - zero = 0 → pc_src = 0.
  - Repeat with eq_neq = 0 (BNE): results inverted.
- imem_ack delayed 5 cycles, TIMEOUT = 16: imem_req is held for 6 cycles, instr_le pulses only in the 6th, no fault.
  - imem_ack never asserted: fault = 1 after exactly 16 FETCH cycles; state = 5; stays there.
  - Then pulse reset: state = 0, instret = 0.
- halt_req asserted in DECODE: WB still occurs and instret increments, then HALT with halted = 1.
  - Hold 10 cycles: no strobes, instret unchanged.
  - Deassert: FETCH next cycle.
- reset asserted during EXEC: no rf_we or pc_we pulse; next cycle state = FETCH, imem_req = 0 while reset is high.
  - Preload instret with 2^CNT_W - 1 retired (CNT_W = 4 build): the next WB wraps instret to 0.
